ex_mem_pipe_stage: RTL and testbench

//  Parametrised EX->MEM pipeline stage. Carries ALU result, store data (Rt),

---
 rtl/ex_mem_pipe_stage.sv | 124 ++++++++++++
 tb/tb_ex_mem_pipe_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage: 2-entry skid buffer with registered ready,
// synchronous flush and a saturating back-pressure cycle counter.
//
// Ports:
//   clk, rst (async, active-low), flush (sync squash)
//   in_valid/in_ready + alu_result_in, rt_in, rd_in, ctrl_in   (from EX)
//   out_valid/out_ready + alu_result_out, rt_out, rd_out, ctrl_out (to MEM)
//   stall_cnt : cycles with out_valid=1 and out_ready=0 (saturating)
module ex_mem_pipe_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int CTRL_W      = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      alu_result_in,
  input  logic [DATA_W-1:0]      rt_in,
  input  logic [REG_ADDR_W-1:0]  rd_in,
  input  logic [CTRL_W-1:0]      ctrl_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      alu_result_out,
  output logic [DATA_W-1:0]      rt_out,
  output logic [REG_ADDR_W-1:0]  rd_out,
  output logic [CTRL_W-1:0]      ctrl_out,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int PL_W = CTRL_W + REG_ADDR_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state;
  logic [PL_W-1:0] main_q;
  logic [PL_W-1:0] skid_q;
  logic [PL_W-1:0] in_pl;
  logic            valid_q;
  logic            ready_q;
  logic            in_fire;
  logic            out_fire;

  assign in_pl    = {ctrl_in, rd_in, rt_in, alu_result_in};
  assign in_fire  = in_valid & ready_q;
  assign out_fire = valid_q & out_ready;

  assign in_ready  = ready_q;
  assign out_valid = valid_q;

  // main_q is zeroed whenever the stage drains, so outputs read 0
  // while out_valid=0 without extra gating.
  assign {ctrl_out, rd_out, rt_out, alu_result_out} = main_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (flush) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q  <= in_pl;
            valid_q <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_pl;
          end else if (in_fire) begin
            skid_q  <= in_pl;
            ready_q <= 1'b0;
            state   <= TWO;
          end else if (out_fire) begin
            main_q  <= '0;
            valid_q <= 1'b0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_q  <= skid_q;
            skid_q  <= '0;
            ready_q <= 1'b1;
            state   <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Counts independently of flush; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (valid_q && !out_ready && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: directed scenarios plus a random run
// against a queue-based FIFO model of capacity two.
module tb_ex_mem_pipe_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] alu_in;
  logic [31:0] rt_in;
  logic [4:0]  rd_in;
  logic [3:0]  ctrl_in;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] alu_out;
  logic [31:0] rt_out;
  logic [4:0]  rd_out;
  logic [3:0]  ctrl_out;
  logic [15:0] stall_cnt;

  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] alu_out2;
  logic [31:0] rt_out2;
  logic [4:0]  rd_out2;
  logic [3:0]  ctrl_out2;
  logic [3:0]  stall_cnt2;

  ex_mem_pipe_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result_in(alu_in), .rt_in(rt_in),
    .rd_in(rd_in), .ctrl_in(ctrl_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result_out(alu_out), .rt_out(rt_out),
    .rd_out(rd_out), .ctrl_out(ctrl_out),
    .stall_cnt(stall_cnt)
  );

  ex_mem_pipe_stage #(.STALL_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2),
    .alu_result_in(alu_in), .rt_in(rt_in),
    .rd_in(rd_in), .ctrl_in(ctrl_in),
    .out_valid(out_valid2), .out_ready(out_ready),
    .alu_result_out(alu_out2), .rt_out(rt_out2),
    .rd_out(rd_out2), .ctrl_out(ctrl_out2),
    .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO contents, ready flag, stall counters.
  logic [72:0] q[$];
  bit          m_ready;
  int          m_cnt;
  int          m_cnt4;

  function automatic logic [72:0] exp_pl();
    if (q.size() != 0) return q[0];
    return '0;
  endfunction

  function automatic logic [72:0] dut_pl();
    return {ctrl_out, rd_out, rt_out, alu_out};
  endfunction

  task automatic model_reset();
    q.delete();
    m_ready = 1'b1;
    m_cnt   = 0;
    m_cnt4  = 0;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_in    = '0;
    rt_in     = '0;
    rd_in     = '0;
    ctrl_in   = '0;
  endtask

  task automatic set_beat(input logic [31:0] a, input logic [31:0] r,
                          input logic [4:0] d, input logic [3:0] c);
    alu_in  = a;
    rt_in   = r;
    rd_in   = d;
    ctrl_in = c;
  endtask

  // One clock: evaluate model events from pre-edge inputs, then
  // advance to 1 time unit after the edge.
  task automatic cycle();
    bit inf;
    bit outf;
    inf  = in_valid && m_ready;
    outf = (q.size() != 0) && out_ready;
    if (q.size() != 0 && !out_ready) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back({ctrl_in, rd_in, rt_in, alu_in});
    end
    m_ready = (q.size() < 2);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1",
               out_valid, in_ready);
    end
    n_cmp++;
    if (dut_pl() !== '0 || stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_pl: pl=%h cnt=%0d want 0/0", dut_pl(), stall_cnt);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      set_beat(32'h10 + i, 32'h100 + i, 5'(i + 1), 4'(i));
      cycle();
      n_cmp++;
      if (out_valid !== 1'b1 || alu_out !== 32'h10 + i ||
          rd_out !== 5'(i + 1) || rt_out !== 32'h100 + i ||
          ctrl_out !== 4'(i)) begin
        n_err++;
        $display("FAIL stream_%0d: v=%b alu=%h rd=%0d want 1/%h/%0d",
                 i, out_valid, alu_out, rd_out, 32'h10 + i, i + 1);
      end
    end
    in_valid = 1'b0;
    cycle();
    n_cmp++;
    if (out_valid !== 1'b0 || dut_pl() !== '0 || stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL stream_drain: v=%b pl=%h cnt=%0d want 0/0/0",
               out_valid, dut_pl(), stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_beat(32'hAAAA0001, 32'h1, 5'd7, 4'hA);
    cycle();
    set_beat(32'hBBBB0002, 32'h2, 5'd8, 4'hB);
    cycle();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || alu_out !== 32'hAAAA0001) begin
      n_err++;
      $display("FAIL bp_two: in_ready=%b alu=%h want 0/aaaa0001",
               in_ready, alu_out);
    end
    repeat (3) cycle();
    // A held for the B-accept cycle plus 3 idle cycles.
    n_cmp++;
    if (stall_cnt !== 16'd4 || alu_out !== 32'hAAAA0001) begin
      n_err++;
      $display("FAIL bp_hold: cnt=%0d alu=%h want 4/aaaa0001",
               stall_cnt, alu_out);
    end
    out_ready = 1'b1;
    cycle();
    n_cmp++;
    if (out_valid !== 1'b1 || alu_out !== 32'hBBBB0002 ||
        rd_out !== 5'd8 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_b: v=%b alu=%h rd=%0d rdy=%b want 1/bbbb0002/8/1",
               out_valid, alu_out, rd_out, in_ready);
    end
    cycle();
    n_cmp++;
    if (out_valid !== 1'b0 || stall_cnt !== 16'(m_cnt) || m_cnt != 4) begin
      n_err++;
      $display("FAIL bp_end: v=%b cnt=%0d want 0/4", out_valid, stall_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_beat(32'hAAAA0001, 32'h1, 5'd1, 4'h1);
    cycle();
    set_beat(32'hBBBB0002, 32'h2, 5'd2, 4'h2);
    cycle();
    set_beat(32'hCCCC0003, 32'h3, 5'd3, 4'h3);
    flush = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || dut_pl() !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_now: v=%b pl=%h rdy=%b want 0/0/1",
               out_valid, dut_pl(), in_ready);
    end
    out_ready = 1'b1;
    repeat (3) begin
      cycle();
      n_cmp++;
      if (out_valid !== 1'b0 || alu_out !== 32'd0) begin
        n_err++;
        $display("FAIL flush_gone: v=%b alu=%h want 0/0", out_valid, alu_out);
      end
    end
    n_cmp++;
    if (stall_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL flush_cnt: cnt=%0d want 2", stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_beat(32'h5A5A5A5A, 32'h0, 5'd9, 4'h4);
    cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    n_cmp++;
    if (stall_cnt2 !== 4'd15 || stall_cnt !== 16'd20) begin
      n_err++;
      $display("FAIL sat: cnt4=%0d cnt16=%0d want 15/20",
               stall_cnt2, stall_cnt);
    end
    repeat (3) cycle();
    n_cmp++;
    if (stall_cnt2 !== 4'd15 || alu_out2 !== 32'h5A5A5A5A) begin
      n_err++;
      $display("FAIL sat_hold: cnt4=%0d alu=%h want 15/5a5a5a5a",
               stall_cnt2, alu_out2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_beat(32'h12345678, 32'h9, 5'd3, 4'hF);
    cycle();
    in_valid = 1'b0;
    cycle();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut_pl() !== '0 ||
        stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL async_rst: v=%b rdy=%b pl=%h cnt=%0d want 0/1/0/0",
               out_valid, in_ready, dut_pl(), stall_cnt);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b1;
    set_beat(32'h0BADF00D, 32'h1, 5'd4, 4'h2);
    cycle();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || alu_out !== 32'h0BADF00D) begin
      n_err++;
      $display("FAIL post_rst: v=%b alu=%h want 1/0badf00d",
               out_valid, alu_out);
    end
  endtask

  task automatic test_random();
    logic [72:0] prev_pl;
    bit          prev_stall;
    int          errs_before;
    do_reset();
    errs_before = n_err;
    for (int i = 0; i < 10000; i++) begin
      prev_pl    = dut_pl();
      prev_stall = out_valid && !out_ready;
      flush      = ($urandom_range(0, 63) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      set_beat($urandom, $urandom, 5'($urandom_range(0, 31)),
               4'($urandom_range(0, 15)));
      if (prev_stall) out_ready = 1'b0;
      prev_stall = prev_stall && !flush;
      cycle();
      n_cmp++;
      if (out_valid !== (q.size() != 0) || in_ready !== m_ready) begin
        n_err++;
        if (n_err - errs_before < 10)
          $display("FAIL rnd_hs @%0d: v=%b rdy=%b want %b/%b", i,
                   out_valid, in_ready, q.size() != 0, m_ready);
      end
      n_cmp++;
      if (dut_pl() !== exp_pl() || stall_cnt !== 16'(m_cnt)) begin
        n_err++;
        if (n_err - errs_before < 10)
          $display("FAIL rnd_pl @%0d: pl=%h cnt=%0d want %h/%0d", i,
                   dut_pl(), stall_cnt, exp_pl(), m_cnt);
      end
      if (prev_stall) begin
        n_cmp++;
        if (dut_pl() !== prev_pl) begin
          n_err++;
          if (n_err - errs_before < 10)
            $display("FAIL rnd_stable @%0d: pl=%h want %h", i,
                     dut_pl(), prev_pl);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturation();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

endmodule
